// File: rtl/video_hv_counter.sv
// video_hv_counter: horizontal/vertical raster counter with programmable line and
// frame totals, registered sync windows, a latched line interrupt and a frame strobe.
// HCO is the combinational line carry used to cascade further counter stages.
module video_hv_counter #(
  parameter int HBITS             = 9,
  parameter int VBITS             = 9,
  parameter int unsigned HTOT_RST = 511,
  parameter int unsigned VTOT_RST = 311
) (
  input  logic                                    CLK,
  input  logic                                    RESETL,
  input  logic                                    CE,
  input  logic                                    CLRL,
  input  logic                                    WRL,
  input  logic [2:0]                              ADDR,
  input  logic [((HBITS > VBITS) ? HBITS : VBITS)-1:0] DIN,
  input  logic                                    INTACK,
  output logic [HBITS-1:0]                        HCNT,
  output logic [VBITS-1:0]                        VCNT,
  output logic                                    HSYNCL,
  output logic                                    VSYNCL,
  output logic                                    HCO,
  output logic                                    LINE_INT,
  output logic                                    FRAME
);

  // Programmable registers
  logic [HBITS-1:0] htot_q, htot_d;
  logic [HBITS-1:0] hss_q,  hss_d;
  logic [HBITS-1:0] hse_q,  hse_d;
  logic [VBITS-1:0] vtot_q, vtot_d;
  logic [VBITS-1:0] vss_q,  vss_d;
  logic [VBITS-1:0] vse_q,  vse_d;
  logic [VBITS-1:0] intln_q, intln_d;

  // Counter and output state
  logic [HBITS-1:0] hcnt_q, hcnt_d;
  logic [VBITS-1:0] vcnt_q, vcnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_int_q, line_int_d;
  logic             frame_q, frame_d;

  // Terminal-count decodes. The all-ones term catches a total written below the
  // current count so the counter still wraps instead of running away.
  logic h_end_s;
  logic v_end_s;
  logic line_end_s;

  assign h_end_s    = (hcnt_q == htot_q) || (hcnt_q == {HBITS{1'b1}});
  assign v_end_s    = (vcnt_q == vtot_q) || (vcnt_q == {VBITS{1'b1}});
  assign line_end_s = CLRL & CE & h_end_s;

  // Cascade carry is the plain equality against HTOT, qualified by the enable.
  assign HCO = CE & (hcnt_q == htot_q);

  // Horizontal and vertical counter next state with the frame strobe
  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    frame_d = 1'b0;
    if (!CLRL) begin
      hcnt_d = {HBITS{1'b0}};
      vcnt_d = {VBITS{1'b0}};
    end else if (CE) begin
      if (h_end_s) begin
        hcnt_d = {HBITS{1'b0}};
        if (v_end_s) begin
          vcnt_d  = {VBITS{1'b0}};
          frame_d = 1'b1;
        end else begin
          vcnt_d = vcnt_q + VBITS'(1);
        end
      end else begin
        hcnt_d = hcnt_q + HBITS'(1);
      end
    end else begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
    end
  end

  // Sync decode from the next-state count so the registered sync lines up with its count
  always_comb begin
    hsync_d = 1'b1;
    vsync_d = 1'b1;
    if (!CLRL) begin
      hsync_d = 1'b1;
      vsync_d = 1'b1;
    end else begin
      hsync_d = ~((hss_q <= hcnt_d) && (hcnt_d < hse_q));
      vsync_d = ~((vss_q <= vcnt_d) && (vcnt_d < vse_q));
    end
  end

  // Line interrupt latch: a set on this edge beats a concurrent acknowledge
  always_comb begin
    line_int_d = line_int_q;
    if (line_end_s && (vcnt_d == intln_q)) begin
      line_int_d = 1'b1;
    end else if (INTACK) begin
      line_int_d = 1'b0;
    end else begin
      line_int_d = line_int_q;
    end
  end

  // Register file write decode; compares this edge still see the old values
  always_comb begin
    htot_d  = htot_q;
    hss_d   = hss_q;
    hse_d   = hse_q;
    vtot_d  = vtot_q;
    vss_d   = vss_q;
    vse_d   = vse_q;
    intln_d = intln_q;
    if (!WRL) begin
      case (ADDR)
        3'd0:    htot_d  = DIN[HBITS-1:0];
        3'd1:    hss_d   = DIN[HBITS-1:0];
        3'd2:    hse_d   = DIN[HBITS-1:0];
        3'd3:    vtot_d  = DIN[VBITS-1:0];
        3'd4:    vss_d   = DIN[VBITS-1:0];
        3'd5:    vse_d   = DIN[VBITS-1:0];
        3'd6:    intln_d = DIN[VBITS-1:0];
        default: intln_d = intln_q;
      endcase
    end else begin
      intln_d = intln_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      hcnt_q     <= {HBITS{1'b0}};
      vcnt_q     <= {VBITS{1'b0}};
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      line_int_q <= 1'b0;
      frame_q    <= 1'b0;
      htot_q     <= HBITS'(HTOT_RST);
      hss_q      <= {HBITS{1'b0}};
      hse_q      <= {HBITS{1'b0}};
      vtot_q     <= VBITS'(VTOT_RST);
      vss_q      <= {VBITS{1'b0}};
      vse_q      <= {VBITS{1'b0}};
      intln_q    <= {VBITS{1'b0}};
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      line_int_q <= line_int_d;
      frame_q    <= frame_d;
      htot_q     <= htot_d;
      hss_q      <= hss_d;
      hse_q      <= hse_d;
      vtot_q     <= vtot_d;
      vss_q      <= vss_d;
      vse_q      <= vse_d;
      intln_q    <= intln_d;
    end
  end

  assign HCNT     = hcnt_q;
  assign VCNT     = vcnt_q;
  assign HSYNCL   = hsync_q;
  assign VSYNCL   = vsync_q;
  assign LINE_INT = line_int_q;
  assign FRAME    = frame_q;

endmodule

// File: tb/tb_video_hv_counter.sv
// tb_video_hv_counter: directed vectors against hand-computed values, with a small
// behavioural model tracking every output on every clock.
module tb_video_hv_counter;

  logic       CLK = 1'b0;
  logic       RESETL;
  logic       CE;
  logic       CLRL;
  logic       WRL;
  logic [2:0] ADDR;
  logic [8:0] DIN;
  logic       INTACK;
  logic [8:0] HCNT;
  logic [8:0] VCNT;
  logic       HSYNCL;
  logic       VSYNCL;
  logic       HCO;
  logic       LINE_INT;
  logic       FRAME;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;

  // Model state
  logic [8:0] mh, mv;
  logic [8:0] m_htot, m_hss, m_hse, m_vtot, m_vss, m_vse, m_intln;
  logic       mhs, mvs, mli, mfr;

  video_hv_counter #(
    .HBITS(9), .VBITS(9), .HTOT_RST(511), .VTOT_RST(311)
  ) dut (
    .CLK(CLK), .RESETL(RESETL), .CE(CE), .CLRL(CLRL), .WRL(WRL),
    .ADDR(ADDR), .DIN(DIN), .INTACK(INTACK),
    .HCNT(HCNT), .VCNT(VCNT), .HSYNCL(HSYNCL), .VSYNCL(VSYNCL),
    .HCO(HCO), .LINE_INT(LINE_INT), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mh = 9'd0; mv = 9'd0; mhs = 1'b1; mvs = 1'b1; mli = 1'b0; mfr = 1'b0;
    m_htot = 9'd511; m_vtot = 9'd311;
    m_hss = 9'd0; m_hse = 9'd0; m_vss = 9'd0; m_vse = 9'd0; m_intln = 9'd0;
  endtask

  task automatic model_edge();
    logic le;
    le = 1'b0;
    if (!CLRL) begin
      mh = 9'd0; mv = 9'd0; mhs = 1'b1; mvs = 1'b1; mfr = 1'b0;
    end else begin
      mfr = 1'b0;
      if (CE) begin
        if (mh == m_htot || mh == 9'h1FF) begin
          mh = 9'd0;
          le = 1'b1;
          if (mv == m_vtot || mv == 9'h1FF) begin
            mv = 9'd0;
            mfr = 1'b1;
          end else begin
            mv = mv + 9'd1;
          end
        end else begin
          mh = mh + 9'd1;
        end
      end
      mhs = !((m_hss <= mh) && (mh < m_hse));
      mvs = !((m_vss <= mv) && (mv < m_vse));
    end
    if (le && mv == m_intln) mli = 1'b1;
    else if (INTACK)         mli = 1'b0;
    if (!WRL) begin
      case (ADDR)
        3'd0: m_htot  = DIN;
        3'd1: m_hss   = DIN;
        3'd2: m_hse   = DIN;
        3'd3: m_vtot  = DIN;
        3'd4: m_vss   = DIN;
        3'd5: m_vse   = DIN;
        3'd6: m_intln = DIN;
        default: ;
      endcase
    end
  endtask

  // One clock: check the carry before the edge, then every registered output after it.
  task automatic tick();
    #1;
    check("hco", HCO, (CE && (mh == m_htot)));
    @(posedge CLK);
    model_edge();
    #1;
    check("hcnt", HCNT, mh);
    check("vcnt", VCNT, mv);
    check("hsyncl", HSYNCL, mhs);
    check("vsyncl", VSYNCL, mvs);
    check("line_int", LINE_INT, mli);
    check("frame", FRAME, mfr);
  endtask

  task automatic wr(input logic [2:0] a, input logic [8:0] d);
    ADDR = a; DIN = d; WRL = 1'b0;
    tick();
    WRL = 1'b1;
  endtask

  task automatic run_until(input int th, input int tv, input int budget);
    int n;
    n = 0;
    while (!(mh == 9'(th) && mv == 9'(tv)) && n < budget) begin
      tick();
      n++;
    end
    check("run_until_timeout", (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int fcount;
    int h, v;
    RESETL = 1'b0; CE = 1'b0; CLRL = 1'b1; WRL = 1'b1;
    ADDR = 3'd0; DIN = 9'd0; INTACK = 1'b0;
    model_reset();
    #23;
    check("rst_hcnt", HCNT, 0);
    check("rst_vcnt", VCNT, 0);
    check("rst_hsyncl", HSYNCL, 1);
    check("rst_vsyncl", VSYNCL, 1);
    check("rst_line_int", LINE_INT, 0);
    check("rst_frame", FRAME, 0);
    RESETL = 1'b1;
    tick();

    // Default totals: full 512-pixel line, then VCNT steps to 1
    CE = 1'b1;
    for (int i = 0; i < 512; i++) begin
      check("t1_hcnt", HCNT, i);
      check("t1_vcnt", VCNT, 0);
      tick();
    end
    check("t1_wrap_h", HCNT, 0);
    check("t1_wrap_v", VCNT, 1);

    // Small raster with sync windows
    CE = 1'b0; CLRL = 1'b0;
    tick();
    CLRL = 1'b1;
    wr(3'd0, 9'd9); wr(3'd3, 9'd3); wr(3'd1, 9'd2);
    wr(3'd2, 9'd5); wr(3'd4, 9'd1); wr(3'd5, 9'd2);
    CE = 1'b1;
    fcount = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      h = (i + 1) % 10;
      v = ((i + 1) / 10) % 4;
      check("t2_hsync_win", HSYNCL, !(h >= 2 && h <= 4));
      check("t2_vsync_win", VSYNCL, !(v == 1));
      check("t2_frame", FRAME, (h == 0 && v == 0));
      if (FRAME) fcount++;
    end
    check("t2_frame_count", fcount, 2);

    // Alternating enable
    CE = 1'b0; CLRL = 1'b0;
    tick();
    CLRL = 1'b1;
    for (int i = 0; i < 16; i++) begin
      CE = (i % 2 == 0);
      tick();
      check("t3_hcnt", HCNT, (i / 2) + 1);
    end

    // Shrink HTOT below the running count
    CE = 1'b0; CLRL = 1'b0;
    tick();
    CLRL = 1'b1; CE = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("t4_at7", HCNT, 7);
    ADDR = 3'd0; DIN = 9'd3; WRL = 1'b0;
    tick();
    WRL = 1'b1;
    check("t4_old_htot", HCNT, 8);
    for (int i = 0; i < 503; i++) tick();
    check("t4_at511", HCNT, 511);
    check("t4_v_before", VCNT, 0);
    tick();
    check("t4_wrap_h", HCNT, 0);
    check("t4_wrap_v", VCNT, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t4_short_line", HCNT, i % 4);
    end
    check("t4_short_v", VCNT, 2);

    // Line interrupt set/ack ordering
    CE = 1'b0;
    wr(3'd0, 9'd9); wr(3'd6, 9'd2);
    INTACK = 1'b1;
    tick();
    INTACK = 1'b0; CLRL = 1'b0;
    tick();
    CLRL = 1'b1;
    check("t5_int_clear", LINE_INT, 0);
    CE = 1'b1;
    run_until(9, 1, 100);
    check("t5_int_low", LINE_INT, 0);
    INTACK = 1'b1;
    tick();
    check("t5_vcnt2", VCNT, 2);
    check("t5_set_wins", LINE_INT, 1);
    tick();
    check("t5_ack", LINE_INT, 0);
    INTACK = 1'b0;

    // Synchronous clear mid-line keeps the interrupt
    run_until(0, 2, 100);
    check("t6_int_set", LINE_INT, 1);
    CE = 1'b0;
    wr(3'd2, 9'd8);
    CE = 1'b1;
    run_until(6, 2, 20);
    check("t6_hsync_low", HSYNCL, 0);
    CLRL = 1'b0;
    tick();
    check("t6_clr_h", HCNT, 0);
    check("t6_clr_v", VCNT, 0);
    check("t6_clr_hsync", HSYNCL, 1);
    check("t6_clr_int", LINE_INT, 1);
    CLRL = 1'b1;

    // Asynchronous reset mid-frame, no clock edge involved
    for (int i = 0; i < 13; i++) tick();
    #2;
    RESETL = 1'b0;
    #1;
    model_reset();
    check("ar_hcnt", HCNT, 0);
    check("ar_vcnt", VCNT, 0);
    check("ar_hsyncl", HSYNCL, 1);
    check("ar_vsyncl", VSYNCL, 1);
    check("ar_line_int", LINE_INT, 0);
    check("ar_frame", FRAME, 0);
    CE = 1'b0;
    @(posedge CLK);
    #1;
    check("ar_held", HCNT, 0);
    RESETL = 1'b1;
    tick();
    CE = 1'b1;
    tick();
    check("ar_restart", HCNT, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
